// File: rtl/store_queue_encoder.sv
// Store path: encodes word/half/byte stores into word address, lane data and
// byte enables, queues them (optional same-word merge) and drains via valid/ready.
// Ports: clk, rst_n | in_valid/in_ready/in_addr/in_data/in_size (store request)
//        mem_valid/mem_ready/mem_addr/mem_data/mem_be (memory port)
//        misalign_err (1-cycle pulse), count (occupied entries)
module store_queue_encoder #(
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 4,
  parameter int MERGE_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [31:0]                in_data,
  input  logic [1:0]                 in_size,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [31:0]                mem_data,
  output logic [3:0]                 mem_be,
  output logic                       misalign_err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int WW = ADDR_W - 2;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [WW-1:0] q_addr [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [3:0]    q_be   [DEPTH];

  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          err_q;

  logic [1:0]    off;
  logic [31:0]   enc_data;
  logic [3:0]    enc_be;
  logic          enc_ok;

  logic          accept;
  logic          push;
  logic          pop;
  logic          merge;
  logic          alloc;

  assign off = in_addr[1:0];

  // Lane 0 is the most significant byte of the data bus.
  always_comb begin
    enc_data = '0;
    enc_be   = '0;
    enc_ok   = 1'b0;
    unique case (in_size)
      2'd0: begin
        if (off == 2'd0) begin
          enc_ok   = 1'b1;
          enc_data = in_data;
          enc_be   = 4'b1111;
        end
      end
      2'd1: begin
        if (!off[0]) begin
          enc_ok   = 1'b1;
          enc_data = off[1] ? {16'h0, in_data[15:0]}
                            : {in_data[15:0], 16'h0};
          enc_be   = off[1] ? 4'b1100 : 4'b0011;
        end
      end
      2'd2: begin
        enc_ok   = 1'b1;
        // shift by 8*(3-off); 3-off == ~off for 2 bits
        enc_data = {24'h0, in_data[7:0]} << {~off, 3'b000};
        enc_be   = 4'b0001 << off;
      end
      default: begin
        enc_ok = 1'b0;
      end
    endcase
  end

  assign in_ready  = (cnt != FULL);
  assign mem_valid = (cnt != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && enc_ok;
  assign pop       = mem_valid && mem_ready;
  assign tail      = wptr - PW'(1);

  // A lone entry leaving this cycle must not absorb the new store.
  assign merge = (MERGE_EN != 0) && push && mem_valid
              && (q_addr[tail] == in_addr[ADDR_W-1:2])
              && !(cnt == ONE && pop);
  assign alloc = push && !merge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (pop)
        rptr <= rptr + PW'(1);
      if (alloc)
        wptr <= wptr + PW'(1);
      if (alloc && !pop)
        cnt <= cnt + ONE;
      else if (pop && !alloc)
        cnt <= cnt - ONE;
      err_q <= accept && !enc_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
        q_be[i]   <= '0;
      end
    end else if (alloc) begin
      q_addr[wptr] <= in_addr[ADDR_W-1:2];
      q_data[wptr] <= enc_data;
      q_be[wptr]   <= enc_be;
    end else if (merge) begin
      for (int k = 0; k < 4; k++)
        if (enc_be[k])
          q_data[tail][31-8*k -: 8] <= enc_data[31-8*k -: 8];
      q_be[tail] <= q_be[tail] | enc_be;
    end
  end

  assign mem_addr     = mem_valid ? {q_addr[rptr], 2'b00} : '0;
  assign mem_data     = mem_valid ? q_data[rptr] : '0;
  assign mem_be       = mem_valid ? q_be[rptr] : '0;
  assign misalign_err = err_q;
  assign count        = cnt;

endmodule

// File: tb/tb_store_queue_encoder.sv
// Bench for store_queue_encoder: directed scenarios plus random traffic
// checked against a byte-level queue model.
module tb_store_queue_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic        misalign_err;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  store_queue_encoder #(
    .ADDR_W(32), .DEPTH(4), .MERGE_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_size(in_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_be(mem_be),
    .misalign_err(misalign_err), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] w;
    logic [31:0] d;
    logic [3:0]  en;
  } ent_t;

  ent_t mq[$];
  bit   m_err;

  // Store value bytes laid out most-significant first from the byte offset.
  task automatic model_tick();
    int   n;
    int   off;
    int   lane;
    bit   rdy;
    bit   acc;
    bit   pop;
    bit   bad;
    bit   mrg;
    ent_t e;
    ent_t t;
    n   = (in_size == 2'd0) ? 4 : (in_size == 2'd1) ? 2
        : (in_size == 2'd2) ? 1 : 0;
    off = int'(in_addr[1:0]);
    bad = (n == 0) || (off % n != 0);
    rdy = mq.size() < 4;
    acc = in_valid && rdy;
    pop = (mq.size() > 0) && mem_ready;
    mrg = acc && !bad && mq.size() >= 1
       && mq[mq.size()-1].w == in_addr[31:2]
       && !(mq.size() == 1 && pop);
    m_err = acc && bad;
    if (pop) void'(mq.pop_front());
    if (acc && !bad) begin
      e = '0;
      e.w = in_addr[31:2];
      for (int i = 0; i < n; i++) begin
        lane = off + i;
        e.d[31-8*lane -: 8] = in_data[8*(n-1-i) +: 8];
        e.en[lane] = 1'b1;
      end
      if (mrg) begin
        t = mq[mq.size()-1];
        for (int k = 0; k < 4; k++)
          if (e.en[k]) t.d[31-8*k -: 8] = e.d[31-8*k -: 8];
        t.en = t.en | e.en;
        mq[mq.size()-1] = t;
      end else begin
        mq.push_back(e);
      end
    end
  endtask

  function automatic logic [73:0] exp_vec();
    logic v;
    ent_t h;
    v = mq.size() != 0;
    h = v ? mq[0] : '0;
    return {v, h.w, 2'b00, h.d, h.en, 3'(mq.size()),
            logic'(mq.size() < 4), logic'(m_err)};
  endfunction

  function automatic logic [73:0] act_vec();
    return {mem_valid, mem_addr, mem_data, mem_be, count,
            in_ready, misalign_err};
  endfunction

  task automatic tick();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_size  = s;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (act_vec() !== {1'b0, 32'h0, 32'h0, 4'h0, 3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got=%h exp=%h", act_vec(),
               {1'b0, 32'h0, 32'h0, 4'h0, 3'd0, 1'b1, 1'b0});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_err = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_word();
    mem_ready = 1'b1;
    drive(32'h1000, 32'hDEADBEEF, 2'd0);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({mem_valid, mem_addr, mem_data, mem_be} !==
        {1'b1, 32'h1000, 32'hDEADBEEF, 4'b1111}) begin
      errors++;
      $display("FAIL word_store: got=%h exp=%h",
               {mem_valid, mem_addr, mem_data, mem_be},
               {1'b1, 32'h1000, 32'hDEADBEEF, 4'b1111});
    end
    tick();
    checks++;
    if (act_vec() !== exp_vec() || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL word_drained: got=%h exp=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_merge();
    mem_ready = 1'b0;
    drive(32'h2001, 32'h000000AB, 2'd2);
    tick();
    drive(32'h2002, 32'h00001234, 2'd1);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({count, mem_addr, mem_data, mem_be} !==
        {3'd1, 32'h2000, 32'h00AB1234, 4'b1110}) begin
      errors++;
      $display("FAIL merge: got=%h exp=%h",
               {count, mem_addr, mem_data, mem_be},
               {3'd1, 32'h2000, 32'h00AB1234, 4'b1110});
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL merge_drain: got=%h exp=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_full_order();
    logic [31:0] want[$];
    logic [31:0] got[$];
    bit          acc_now;
    bit          both;
    logic [2:0]  cnt_before;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'h5000 + 32'(16 * i), $urandom, 2'd0);
      want.push_back(32'h5000 + 32'(16 * i));
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if ({count, in_ready} !== {3'd4, 1'b0}) begin
      errors++;
      $display("FAIL full: got=%h exp=%h", {count, in_ready}, {3'd4, 1'b0});
    end
    mem_ready = 1'b1;
    drive(32'h5040, 32'h55AA55AA, 2'd0);
    want.push_back(32'h5040);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL full_cycle%0d: got=%h exp=%h", c, act_vec(),
                 exp_vec());
      end
      if (mem_valid) got.push_back(mem_addr);
      acc_now    = in_valid && in_ready;
      both       = acc_now && mem_valid;
      cnt_before = count;
      tick();
      if (acc_now) in_valid = 1'b0;
      if (both) begin
        checks++;
        if (count !== cnt_before) begin
          errors++;
          $display("FAIL push_pop_count: got=%0d exp=%0d", count,
                   cnt_before);
        end
      end
    end
    checks++;
    if (got.size() != 5 || got != want) begin
      errors++;
      $display("FAIL order: got=%p exp=%p", got, want);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_misalign();
    drive(32'h3002, 32'h12345678, 2'd0);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({misalign_err, count, mem_valid} !== {1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL misalign_pulse: got=%h exp=%h",
               {misalign_err, count, mem_valid}, {1'b1, 3'd0, 1'b0});
    end
    tick();
    checks++;
    if ({misalign_err, count, mem_valid} !== {1'b0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL misalign_end: got=%h exp=%h",
               {misalign_err, count, mem_valid}, {1'b0, 3'd0, 1'b0});
    end
  endtask

  task automatic test_no_merge_on_pop();
    mem_ready = 1'b0;
    drive(32'h4000, 32'h00000011, 2'd2);
    tick();
    mem_ready = 1'b1;
    drive(32'h4003, 32'h0000005A, 2'd2);
    tick();
    in_valid  = 1'b0;
    mem_ready = 1'b0;
    checks++;
    if ({count, mem_addr, mem_data, mem_be} !==
        {3'd1, 32'h4000, 32'h0000005A, 4'b1000}) begin
      errors++;
      $display("FAIL pop_no_merge: got=%h exp=%h",
               {count, mem_addr, mem_data, mem_be},
               {3'd1, 32'h4000, 32'h0000005A, 4'b1000});
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h7000 + 32'(4 * i), $urandom, 2'd0);
      tick();
    end
    in_valid  = 1'b0;
    mem_ready = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_err = 0;
    checks++;
    if ({mem_valid, count} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL async_reset: got=%h exp=%h", {mem_valid, count},
               {1'b0, 3'd0});
    end
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (act_vec() !== exp_vec() || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL post_reset%0d: got=%h exp=%h", c, act_vec(),
                 exp_vec());
      end
      tick();
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random%0d: got=%h exp=%h", c, act_vec(), exp_vec());
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_addr   = 32'h6000 + 32'($urandom_range(0, 11));
      in_data   = $urandom;
      in_size   = 2'($urandom_range(0, 3));
      mem_ready = ($urandom_range(0, 2) == 0);
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    in_size   = '0;
    mem_ready = 1'b0;
    m_err     = 0;
    test_reset();
    test_word();
    test_merge();
    test_full_order();
    test_misalign();
    test_no_merge_on_pop();
    test_reset_mid_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_queue_encoder.md
Name: store_queue_encoder

Overview:
- Parametrised store path between the CPU MEM stage and the data-memory port.
- Each accepted store (word/half/byte) is converted into a word-aligned address, lane-positioned data and a 4-bit byte-enable mask, then queued in a DEPTH-entry FIFO.
- The FIFO drains over a valid/ready memory handshake.
- Optionally merges consecutive stores to the same word.
- Flags misaligned stores instead of silently writing zero.

Parameters:
- ADDR_W, 32: byte-address width.
- DEPTH, 4: queue entries; power of two, at least 2.
- MERGE_EN, 1: 1 enables same-word merge into the tail entry; 0 disables it.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  store request valid.
- in_ready  output  1  queue can accept a request.
- in_addr  input  ADDR_W  store byte address.
- in_data  input  32  store data, right-justified.
- in_size  input  2  store size: 0=word, 1=half, 2=byte, 3=reserved.
- mem_valid  output  1  head entry valid.
- mem_ready  input  1  memory accepts head entry.
- mem_addr  output  ADDR_W  head word address; bits [1:0] always 0.
- mem_data  output  32  head lane-positioned data.
- mem_be  output  4  head byte enables.
- misalign_err  output  1  one-cycle pulse after a misaligned store is accepted.
- count  output  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Lane map:
  - Byte offset o = in_addr[1:0].
  - Lane k occupies data bits [31-8k:24-8k] and is enabled by be bit k.
- Encoding:
  - Word, o=0: data = in_data; be = 1111.
  - Half, o=0: data = {in_data[15:0], 16'h0}; be = 0011.
  - Half, o=2: data = {16'h0, in_data[15:0]}; be = 1100.
  - Byte, any o: in_data[7:0] placed in lane o; all other lanes 0; be = one-hot bit o.
- Misaligned cases: word with o≠0, half with odd o, or in_size=3.
  - Request is accepted (handshake completes) but not queued.
  - misalign_err = 1 on the following cycle only.
  - count and entries are unchanged.
- Accept: in_valid && in_ready.
  - in_ready = (count != DEPTH), derived from registered state only; no combinational path from mem_ready or in_valid.
- Pop: mem_valid && mem_ready.
  - mem_valid = (count != 0).
  - mem_addr/mem_data/mem_be come from the head entry register and hold stable while stalled.
  - When empty, all three read 0.
- Latency: a store accepted in cycle N is presented at the earliest in cycle N+1.
- Merge, when MERGE_EN=1:
  - Conditions: aligned accept, count ≥ 1, tail word address == in_addr[ADDR_W-1:2], and not (count==1 && pop this cycle).
  - Lanes set in the new be overwrite the tail data lanes; tail be |= new be; count unchanged.
  - A merge is allowed even when full only if in_ready is 1, i.e. never when full.
  - Merge never targets a head entry that is being popped in the same cycle; allocate a new entry instead.
- Simultaneous push (non-merge) and pop: count unchanged; head and tail pointers both advance.
- Pointers wrap modulo DEPTH. A pop when empty or a push when full cannot occur by construction.
- Reset (any time, including mid-drain):
  - Pointers, count, entries, mem_valid and misalign_err clear to 0; in_ready = 1.
  - All queued stores are discarded; no partial mem handshake is completed.

Test Plan:
- SW 0x1000, data 0xDEADBEEF, mem_ready=1 → next cycle mem_valid=1, mem_addr=0x1000, mem_data=0xDEADBEEF, mem_be=1111; then empty.
- SB to 0x2001 data 0xAB, then SH to 0x2002 data 0x1234 (MERGE_EN=1, mem_ready=0) → count=1, mem_addr=0x2000, mem_data=0x00AB1234, mem_be=1110.
- mem_ready=0, push 4 stores to distinct words → count=4, in_ready=0. Raise mem_ready plus push a 5th → order preserved, count holds at 4 during simultaneous push/pop.
- SW to 0x3002 → misalign_err pulses exactly one cycle; count stays 0; mem_valid stays 0.
- count=1 with same-word SB to 0x4003 while head pops → new entry allocated, no merge; next head mem_be=1000, data=0x000000xx.
- Queue holding 3 entries, assert rst_n=0 mid-drain → mem_valid=0 and count=0 immediately; after release in_ready=1 and no stale entry is emitted.
